// File: rtl/bsx_pkg.sv
// Shared types and constants for the BS-X page fetch block.
// State encoding, page-region offsets and the debug view of internal state.
package bsx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [8:0] DATA_OFS   = 9'h048;
    localparam logic [8:0] STA_OFS    = 9'h032;
    localparam logic [8:0] STB_OFS    = 9'h034;
    localparam int unsigned PAGE_BYTES = 512;

    typedef struct packed {
        state_e     state;
        logic [4:0] byte_cnt0;
        logic [4:0] byte_cnt1;
    } dbg_t;

    // Pages are PAGE_BYTES long, so page*512+offset is a plain concatenation.
    function automatic logic [23:0] page_addr(input logic [23:0] base,
                                              input logic [9:0]  page,
                                              input logic [8:0]  ofs);
        return base + {5'b0, page, ofs};
    endfunction

endpackage

// File: rtl/bsx_page_fetch_if.sv
// Single-beat RAM read port: ram_req is held until a 1-cycle ram_ack,
// and ram_rdata is valid in the ack cycle.
interface bsx_page_fetch_if;

    logic        ram_req;
    logic [23:0] ram_addr;
    logic        ram_ack;
    logic [7:0]  ram_rdata;

    modport master (output ram_req, output ram_addr, input ram_ack, input ram_rdata);
    modport slave  (input ram_req, input ram_addr, output ram_ack, output ram_rdata);

endinterface

// File: rtl/bsx_frame_counter.sv
// Per-channel consumption tracker: byte counter within a frame, sticky
// frame_done flag and saturating count of completed frames.
module bsx_frame_counter #(
    parameter logic [8:0] FRAME_BYTES = 9'd22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_restart,
    input  logic       i_clr,
    output logic       o_done,
    output logic [7:0] o_frame_cnt,
    output logic [4:0] o_byte_cnt
);

    localparam logic [8:0] LAST_FULL = FRAME_BYTES - 9'd1;
    localparam logic [4:0] LAST      = LAST_FULL[4:0];

    logic [4:0] r_byte;
    logic       r_done;
    logic [7:0] r_cnt;
    logic       w_complete;

    // Restart beats a coincident increment, so no frame can complete then.
    assign w_complete = i_inc && !i_restart && (r_byte == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte <= 5'd0;
            r_done <= 1'b0;
            r_cnt  <= 8'd0;
        end else begin
            if (i_restart) begin
                r_byte <= 5'd0;
            end else if (i_inc) begin
                r_byte <= w_complete ? 5'd0 : r_byte + 5'd1;
            end

            // A clear landing on a completion keeps that completion.
            if (w_complete) begin
                r_done <= 1'b1;
            end else if (i_clr) begin
                r_done <= 1'b0;
            end

            if (i_clr) begin
                r_cnt <= w_complete ? 8'd1 : 8'd0;
            end else if (w_complete && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_done      = r_done;
    assign o_frame_cnt = r_cnt;
    assign o_byte_cnt  = r_byte;

endmodule

// File: rtl/bsx_page_fetch.sv
// Turns redirected SNES base-register reads into single-beat RAM reads and
// tracks per-channel broadcast frame consumption for the MCU.
module bsx_page_fetch #(
    parameter logic [23:0] BS_BASE     = 24'hFC0000,
    parameter logic [8:0]  FRAME_BYTES = 9'd22,
    parameter logic [8:0]  DATA_OFS    = 9'h048
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                bs_page_enable,
    input  logic [9:0]          bs_page_out,
    input  logic [8:0]          bs_page_offset,
    input  logic                bs_chan,
    input  logic                reg_oe_falling,
    input  logic                reg_oe_rising,
    input  logic [1:0]          page_wr,
    bsx_page_fetch_if.master    ram,
    output logic [7:0]          bs_data_out,
    output logic                bs_data_valid,
    output logic [1:0]          frame_done,
    output logic [7:0]          frame_cnt0,
    output logic [7:0]          frame_cnt1,
    output logic [7:0]          miss_cnt,
    input  logic [1:0]          mcu_clr,
    output bsx_pkg::dbg_t       dbg
);

    bsx_pkg::state_e r_state;
    bsx_pkg::state_e w_next;

    logic        r_req;
    logic [23:0] r_addr;
    logic [7:0]  r_data;
    logic        r_valid;
    logic [7:0]  r_miss;
    logic        w_start;
    logic        w_consume;
    logic [4:0]  w_byte0;
    logic [4:0]  w_byte1;

    assign w_start = reg_oe_falling && bs_page_enable;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= bsx_pkg::ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An ack wins over a coincident strobe end; the strobe end still returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            bsx_pkg::ST_IDLE: if (w_start) w_next = bsx_pkg::ST_REQ;
            bsx_pkg::ST_REQ: begin
                if (ram.ram_ack) begin
                    w_next = reg_oe_rising ? bsx_pkg::ST_IDLE : bsx_pkg::ST_HOLD;
                end else if (reg_oe_rising) begin
                    w_next = bsx_pkg::ST_IDLE;
                end
            end
            bsx_pkg::ST_HOLD: if (reg_oe_rising) w_next = bsx_pkg::ST_IDLE;
            default: w_next = bsx_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_addr  <= 24'd0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_miss  <= 8'd0;
        end else begin
            case (r_state)
                bsx_pkg::ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_start) begin
                        r_addr <= bsx_pkg::page_addr(BS_BASE, bs_page_out, bs_page_offset);
                        r_req  <= 1'b1;
                    end
                end
                bsx_pkg::ST_REQ: begin
                    if (ram.ram_ack) begin
                        r_data  <= ram.ram_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                    end else if (reg_oe_rising) begin
                        r_req   <= 1'b0;
                        r_data  <= 8'h00;
                        r_valid <= 1'b0;
                        if (r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
                    end
                end
                bsx_pkg::ST_HOLD: begin
                    if (reg_oe_rising) r_valid <= 1'b0;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Only data-region bytes count towards a frame; status/stb reads do not.
    assign w_consume = reg_oe_rising && bs_page_enable && (bs_page_offset >= DATA_OFS);

    bsx_frame_counter #(.FRAME_BYTES(FRAME_BYTES)) u_fc0 (
        .clk         (clkin),
        .rst_n       (rst_n),
        .i_inc       (w_consume && !bs_chan),
        .i_restart   (page_wr[0]),
        .i_clr       (mcu_clr[0]),
        .o_done      (frame_done[0]),
        .o_frame_cnt (frame_cnt0),
        .o_byte_cnt  (w_byte0)
    );

    bsx_frame_counter #(.FRAME_BYTES(FRAME_BYTES)) u_fc1 (
        .clk         (clkin),
        .rst_n       (rst_n),
        .i_inc       (w_consume && bs_chan),
        .i_restart   (page_wr[1]),
        .i_clr       (mcu_clr[1]),
        .o_done      (frame_done[1]),
        .o_frame_cnt (frame_cnt1),
        .o_byte_cnt  (w_byte1)
    );

    assign ram.ram_req    = r_req;
    assign ram.ram_addr   = r_addr;
    assign bs_data_out    = r_data;
    assign bs_data_valid  = r_valid;
    assign miss_cnt       = r_miss;
    assign dbg.state      = r_state;
    assign dbg.byte_cnt0  = w_byte0;
    assign dbg.byte_cnt1  = w_byte1;

endmodule

// File: tb/tb_bsx_page_fetch.sv
// Directed bench for bsx_page_fetch: fetch timing, misses, frame tracking,
// saturation, clear/restart priority and reset mid-fetch.
module tb_bsx_page_fetch;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic        bs_page_enable;
  logic [9:0]  bs_page_out;
  logic [8:0]  bs_page_offset;
  logic        bs_chan;
  logic        reg_oe_falling;
  logic        reg_oe_rising;
  logic [1:0]  page_wr;
  logic [1:0]  mcu_clr;
  logic [7:0]  bs_data_out;
  logic        bs_data_valid;
  logic [1:0]  frame_done;
  logic [7:0]  frame_cnt0;
  logic [7:0]  frame_cnt1;
  logic [7:0]  miss_cnt;
  bsx_pkg::dbg_t dbg;

  bsx_page_fetch_if ram_if ();

  bsx_page_fetch dut (
    .clkin          (clkin),
    .rst_n          (rst_n),
    .bs_page_enable (bs_page_enable),
    .bs_page_out    (bs_page_out),
    .bs_page_offset (bs_page_offset),
    .bs_chan        (bs_chan),
    .reg_oe_falling (reg_oe_falling),
    .reg_oe_rising  (reg_oe_rising),
    .page_wr        (page_wr),
    .ram            (ram_if),
    .bs_data_out    (bs_data_out),
    .bs_data_valid  (bs_data_valid),
    .frame_done     (frame_done),
    .frame_cnt0     (frame_cnt0),
    .frame_cnt1     (frame_cnt1),
    .miss_cnt       (miss_cnt),
    .mcu_clr        (mcu_clr),
    .dbg            (dbg)
  );

  // clock / reset
  always #5 clkin = ~clkin;

  localparam logic [8:0] DOFS = 9'h048;
  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_REQ  = 32'd1;
  localparam logic [31:0] S_HOLD = 32'd2;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // reference model of consumption tracking
  logic [4:0] m_byte[2];
  logic [1:0] m_done;
  logic [7:0] m_frames[2];
  logic [7:0] m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: got %0h want <empty queue>", tag, bs_data_out);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(bs_data_out), 32'(e));
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_byte[c] = 5'd0;
      m_frames[c] = 8'd0;
    end
    m_done = 2'b00;
    m_miss = 8'd0;
  endtask

  // one cycle of strobe-end / page_wr / mcu_clr activity, model updated alongside
  task automatic ev(input bit do_rise, input logic ch, input logic [8:0] ofs,
                    input logic [1:0] pw, input logic [1:0] clr);
    bit comp;
    bs_page_enable = 1'b1;
    bs_chan = ch;
    bs_page_offset = ofs;
    page_wr = pw;
    mcu_clr = clr;
    reg_oe_rising = do_rise;
    step();
    reg_oe_rising = 1'b0;
    page_wr = 2'b00;
    mcu_clr = 2'b00;
    for (int c = 0; c < 2; c++) begin
      comp = 1'b0;
      if (pw[c]) begin
        m_byte[c] = 5'd0;
      end else if (do_rise && (int'(ch) == c) && (ofs >= DOFS)) begin
        if (m_byte[c] == 5'd21) begin
          m_byte[c] = 5'd0;
          comp = 1'b1;
        end else begin
          m_byte[c] = m_byte[c] + 5'd1;
        end
      end
      if (clr[c]) begin
        m_done[c] = comp;
        m_frames[c] = comp ? 8'd1 : 8'd0;
      end else if (comp) begin
        m_done[c] = 1'b1;
        if (m_frames[c] != 8'hFF) m_frames[c] = m_frames[c] + 8'd1;
      end
    end
  endtask

  task automatic fetch_start(input logic [9:0] page, input logic [8:0] ofs, input logic ch);
    bs_page_enable = 1'b1;
    bs_page_out = page;
    bs_page_offset = ofs;
    bs_chan = ch;
    reg_oe_falling = 1'b1;
    step();
    reg_oe_falling = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, ".byte0"}, 32'(dbg.byte_cnt0), 32'(m_byte[0]));
    chk({tag, ".byte1"}, 32'(dbg.byte_cnt1), 32'(m_byte[1]));
    chk({tag, ".done"},  32'(frame_done), 32'(m_done));
    chk({tag, ".cnt0"},  32'(frame_cnt0), 32'(m_frames[0]));
    chk({tag, ".cnt1"},  32'(frame_cnt1), 32'(m_frames[1]));
    chk({tag, ".miss"},  32'(miss_cnt), 32'(m_miss));
  endtask

  initial begin
    rst_n = 1'b0;
    bs_page_enable = 1'b0;
    bs_page_out = 10'd0;
    bs_page_offset = 9'd0;
    bs_chan = 1'b0;
    reg_oe_falling = 1'b0;
    reg_oe_rising = 1'b0;
    page_wr = 2'b00;
    mcu_clr = 2'b00;
    ram_if.ram_ack = 1'b0;
    ram_if.ram_rdata = 8'h00;
    model_reset();
    step();
    step();

    // reset state
    chk("rst.req", 32'(ram_if.ram_req), 32'd0);
    chk("rst.addr", 32'(ram_if.ram_addr), 32'd0);
    chk("rst.data", 32'(bs_data_out), 32'h00);
    chk("rst.valid", 32'(bs_data_valid), 32'd0);
    chk("rst.state", 32'(dbg.state), S_IDLE);
    check_counters("rst");
    rst_n = 1'b1;
    step();

    // basic fetch: page 3 offset 0x48, ack three cycles after the request rises
    fetch_start(10'h003, 9'h048, 1'b0);
    chk("f1.req0", 32'(ram_if.ram_req), 32'd1);
    chk("f1.addr", 32'(ram_if.ram_addr), 32'hFC0648);
    chk("f1.state", 32'(dbg.state), S_REQ);
    chk("f1.valid0", 32'(bs_data_valid), 32'd0);
    bs_page_out = 10'h155;
    reg_oe_falling = 1'b1;
    step();
    reg_oe_falling = 1'b0;
    bs_page_out = 10'h003;
    chk("f1.req1", 32'(ram_if.ram_req), 32'd1);
    chk("f1.addr_kept", 32'(ram_if.ram_addr), 32'hFC0648);
    step();
    chk("f1.req2", 32'(ram_if.ram_req), 32'd1);
    ram_if.ram_ack = 1'b1;
    ram_if.ram_rdata = 8'hA5;
    exp_q.push_back(8'hA5);
    step();
    ram_if.ram_ack = 1'b0;
    ram_if.ram_rdata = 8'h00;
    chk("f1.req_drop", 32'(ram_if.ram_req), 32'd0);
    chk("f1.valid", 32'(bs_data_valid), 32'd1);
    chk_data("f1.data");
    chk("f1.hold", 32'(dbg.state), S_HOLD);
    step();
    chk("f1.valid_hold", 32'(bs_data_valid), 32'd1);
    chk("f1.data_hold", 32'(bs_data_out), 32'hA5);
    ev(1'b1, 1'b0, 9'h048, 2'b00, 2'b00);
    chk("f1.valid_off", 32'(bs_data_valid), 32'd0);
    chk("f1.idle", 32'(dbg.state), S_IDLE);
    check_counters("f1");

    // miss: strobe ends six cycles after it started, ack arrives late
    fetch_start(10'h003, 9'h050, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("miss.req", 32'(ram_if.ram_req), 32'd1);
      chk("miss.valid", 32'(bs_data_valid), 32'd0);
      step();
    end
    ev(1'b1, 1'b0, 9'h050, 2'b00, 2'b00);
    m_miss = m_miss + 8'd1;
    chk("miss.req_off", 32'(ram_if.ram_req), 32'd0);
    chk("miss.data", 32'(bs_data_out), 32'h00);
    chk("miss.valid_off", 32'(bs_data_valid), 32'd0);
    chk("miss.state", 32'(dbg.state), S_IDLE);
    ram_if.ram_ack = 1'b1;
    ram_if.ram_rdata = 8'h77;
    step();
    ram_if.ram_ack = 1'b0;
    chk("late.state", 32'(dbg.state), S_IDLE);
    chk("late.valid", 32'(bs_data_valid), 32'd0);
    chk("late.data", 32'(bs_data_out), 32'h00);
    check_counters("miss");

    // ack and strobe end together: data captured, no miss, straight back to IDLE
    fetch_start(10'h007, 9'h034, 1'b0);
    chk("both.addr", 32'(ram_if.ram_addr), 32'hFC0E34);
    ram_if.ram_ack = 1'b1;
    ram_if.ram_rdata = 8'h5A;
    exp_q.push_back(8'h5A);
    ev(1'b1, 1'b0, 9'h034, 2'b00, 2'b00);
    ram_if.ram_ack = 1'b0;
    chk("both.valid", 32'(bs_data_valid), 32'd1);
    chk_data("both.data");
    chk("both.state", 32'(dbg.state), S_IDLE);
    chk("both.req", 32'(ram_if.ram_req), 32'd0);
    step();
    chk("both.valid_off", 32'(bs_data_valid), 32'd0);
    check_counters("both");

    // channel 1: one full frame, then stb-offset reads that must not count
    for (int i = 0; i < 22; i++) ev(1'b1, 1'b1, DOFS + 9'(i), 2'b00, 2'b00);
    chk("ch1.done", 32'(frame_done), 32'b10);
    chk("ch1.cnt", 32'(frame_cnt1), 32'd1);
    check_counters("ch1");
    for (int i = 0; i < 10; i++) ev(1'b1, 1'b1, 9'h034, 2'b00, 2'b00);
    check_counters("ch1_stb");

    // channel 0 restart: page_wr alone, then page_wr coincident with a read
    ev(1'b0, 1'b0, DOFS, 2'b01, 2'b00);
    for (int i = 0; i < 5; i++) ev(1'b1, 1'b0, DOFS, 2'b00, 2'b00);
    ev(1'b1, 1'b0, 9'h060, 2'b01, 2'b00);
    check_counters("pw_coinc");
    for (int i = 0; i < 10; i++) ev(1'b1, 1'b0, DOFS, 2'b00, 2'b00);
    ev(1'b0, 1'b0, DOFS, 2'b01, 2'b00);
    check_counters("pw_restart");
    for (int i = 0; i < 21; i++) ev(1'b1, 1'b0, 9'h1FF, 2'b00, 2'b00);
    chk("pw.cnt_21", 32'(frame_cnt0), 32'd0);
    ev(1'b1, 1'b0, 9'h1FF, 2'b00, 2'b00);
    chk("pw.cnt_22", 32'(frame_cnt0), 32'd1);
    check_counters("pw_frame");

    // saturation of frame_cnt0 at 255
    for (int i = 0; i < 254 * 22; i++) ev(1'b1, 1'b0, DOFS, 2'b00, 2'b00);
    chk("sat.255", 32'(frame_cnt0), 32'hFF);
    for (int i = 0; i < 22; i++) ev(1'b1, 1'b0, DOFS, 2'b00, 2'b00);
    chk("sat.stay", 32'(frame_cnt0), 32'hFF);
    check_counters("sat");

    // mcu_clr alone, then coincident with a frame completion
    ev(1'b0, 1'b0, DOFS, 2'b00, 2'b01);
    chk("clr.done", 32'(frame_done), 32'b10);
    chk("clr.cnt", 32'(frame_cnt0), 32'd0);
    for (int i = 0; i < 21; i++) ev(1'b1, 1'b0, DOFS, 2'b00, 2'b00);
    ev(1'b1, 1'b0, DOFS, 2'b00, 2'b01);
    chk("clr_coinc.done", 32'(frame_done), 32'b11);
    chk("clr_coinc.cnt", 32'(frame_cnt0), 32'd1);
    check_counters("clr_coinc");

    // reset in the middle of a fetch, top-of-range address wraps in 24 bits
    fetch_start(10'h3FF, 9'h1FF, 1'b1);
    chk("rf.req", 32'(ram_if.ram_req), 32'd1);
    chk("rf.addr", 32'(ram_if.ram_addr), 32'h03FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rf.req_async", 32'(ram_if.ram_req), 32'd0);
    chk("rf.state", 32'(dbg.state), S_IDLE);
    model_reset();
    check_counters("rf");
    step();
    rst_n = 1'b1;
    step();
    fetch_start(10'h001, 9'h000, 1'b0);
    chk("post.addr", 32'(ram_if.ram_addr), 32'hFC0200);
    chk("post.req", 32'(ram_if.ram_req), 32'd1);
    ram_if.ram_ack = 1'b1;
    ram_if.ram_rdata = 8'h3C;
    exp_q.push_back(8'h3C);
    step();
    ram_if.ram_ack = 1'b0;
    chk("post.valid", 32'(bs_data_valid), 32'd1);
    chk_data("post.data");
    ev(1'b1, 1'b0, 9'h000, 2'b00, 2'b00);
    chk("post.idle", 32'(dbg.state), S_IDLE);
    check_counters("post");
    chk("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
